pingpong_pe_ctrl: RTL and testbench

//  Single-clock sequencer for the ping-pong input buffer that feeds the PE array (272-bit / 34-byte parallel word).

---
 rtl/pingpong_pe_ctrl.sv | 95 +++++++++
 tb/tb_pingpong_pe_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_pe_ctrl.sv
// pingpong_pe_ctrl: ping-pong input buffer sequencer feeding the PE array.
// Optional watchdog on the PE run phase is enabled by defining PINGPONG_TIMEOUT_EN.
module pingpong_pe_ctrl #(
  parameter int BANK_BYTES  = 34,
  parameter int AW          = 6,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          i_data_din_vld,
  output logic          o_din_rdy,
  output logic          o_wr_bank,
  output logic [AW-1:0] o_wr_addr,
  output logic [1:0]    o_bank_full,
  output logic          o_rd_sel,
  output logic          o_switch_pingpong,
  output logic          o_pe_start,
  input  logic          i_pe_done,
  output logic          o_pe_busy,
  output logic [15:0]   o_frame_cnt,
  output logic          o_err_timeout
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_RELEASE} state_t;
  localparam int SW = $clog2(SETUP_CYC + 1);
  state_t state, state_nxt;
  logic [SW-1:0] set_cnt;
  logic accept, last, rel, start_nxt, tmo;
  assign o_din_rdy = en && !o_bank_full[o_wr_bank];
  assign accept    = i_data_din_vld && o_din_rdy;
  assign last      = o_wr_addr == AW'(BANK_BYTES - 1);
  assign rel       = state == S_RELEASE;
`ifdef PINGPONG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] run_cnt;
  assign tmo = run_cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt       <= '0;
      o_err_timeout <= 1'b0;
    end else begin
      run_cnt <= (state == S_RUN) ? run_cnt + 1'b1 : '0;
      if (state == S_RUN && !i_pe_done && tmo) o_err_timeout <= 1'b1;
    end
  end
`else
  assign tmo           = 1'b0;
  assign o_err_timeout = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    case (state)
      S_IDLE:  if (en && o_bank_full[o_rd_sel]) state_nxt = S_SETUP;
      S_SETUP: if (set_cnt == '0) begin
        state_nxt = S_RUN;
        start_nxt = 1'b1;
      end
      S_RUN:   if (i_pe_done || tmo) state_nxt = S_RELEASE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      set_cnt           <= '0;
      o_wr_bank         <= 1'b0;
      o_wr_addr         <= '0;
      o_bank_full       <= 2'b00;
      o_rd_sel          <= 1'b0;
      o_switch_pingpong <= 1'b0;
      o_pe_start        <= 1'b0;
      o_pe_busy         <= 1'b0;
      o_frame_cnt       <= '0;
    end else begin
      state             <= state_nxt;
      set_cnt           <= (state == S_SETUP) ? set_cnt - 1'b1 : SW'(SETUP_CYC - 1);
      o_pe_start        <= start_nxt;
      o_pe_busy         <= state_nxt == S_SETUP || state_nxt == S_RUN;
      o_switch_pingpong <= rel;
      if (rel) begin
        o_rd_sel    <= !o_rd_sel;
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
      if (accept) begin
        o_wr_addr <= last ? '0 : o_wr_addr + 1'b1;
        if (last) o_wr_bank <= !o_wr_bank;
      end
      // a fill completing on one bank and a release of the other land in the same edge
      o_bank_full <= (o_bank_full | ((accept && last) ? 2'b01 << o_wr_bank : 2'b00))
                     & ~(rel ? 2'b01 << o_rd_sel : 2'b00);
    end
  end
endmodule

// File: tb/tb_pingpong_pe_ctrl.sv
// tb_pingpong_pe_ctrl: directed scenarios plus randomized traffic against a cycle-timed
// behavioural model of bank occupancy and PE scheduling.
module tb_pingpong_pe_ctrl;
  localparam int BB    = 34;
  localparam int SETUP = 2;
`ifdef PINGPONG_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  logic clk = 0, rst_n, en = 0, vld = 0, done = 0;
  logic o_din_rdy, o_wr_bank, o_rd_sel, o_switch_pingpong, o_pe_start, o_pe_busy, o_err_timeout;
  logic [5:0] o_wr_addr;
  logic [1:0] o_bank_full;
  logic [15:0] o_frame_cnt;
  int errors = 0, checks = 0;
  bit chk_on = 0;
  pingpong_pe_ctrl #(.BANK_BYTES(BB), .AW(6), .SETUP_CYC(SETUP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .i_data_din_vld(vld), .o_din_rdy(o_din_rdy),
    .o_wr_bank(o_wr_bank), .o_wr_addr(o_wr_addr), .o_bank_full(o_bank_full), .o_rd_sel(o_rd_sel),
    .o_switch_pingpong(o_switch_pingpong), .o_pe_start(o_pe_start), .i_pe_done(done),
    .o_pe_busy(o_pe_busy), .o_frame_cnt(o_frame_cnt), .o_err_timeout(o_err_timeout));
  always #5 clk = ~clk;
  wire [30:0] dut_vec = {o_din_rdy, o_wr_bank, o_wr_addr, o_bank_full, o_rd_sel, o_switch_pingpong,
                         o_pe_start, o_pe_busy, o_frame_cnt, o_err_timeout};
  // model: bytes written per bank, FIFO order of full banks, and elapsed time since a PE job was taken
  int m_addr = 0, m_t = 0;
  bit m_wb = 0, m_rd = 0, m_act = 0, m_rel = 0, m_sw = 0, m_err = 0;
  bit [1:0] m_full = 0;
  bit [15:0] m_frame = 0;
  initial forever begin : monitor
    bit [1:0] nf;
    bit acc;
    bit [30:0] exp_vec;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_addr = 0; m_t = 0; m_wb = 0; m_rd = 0; m_act = 0; m_rel = 0; m_sw = 0; m_err = 0;
      m_full = 0; m_frame = 0;
    end else begin
      acc = vld && en && !m_full[m_wb];
      nf = m_full;
      m_sw = 0;
      if (acc) begin
        if (m_addr == BB - 1) begin
          nf[m_wb] = 1; m_addr = 0; m_wb = !m_wb;
        end else m_addr++;
      end
      if (m_rel) begin
        nf[m_rd] = 0; m_rd = !m_rd; m_frame++; m_sw = 1; m_act = 0; m_rel = 0;
      end else if (m_act) begin
        if (m_t > SETUP && done) m_rel = 1;
`ifdef PINGPONG_TIMEOUT_EN
        else if (m_t == SETUP + TMO) begin m_rel = 1; m_err = 1; end
`endif
        m_t++;
      end else if (en && m_full[m_rd]) begin
        m_act = 1; m_t = 1;
      end
      m_full = nf;
      #1;
      exp_vec = {en && !m_full[m_wb], m_wb, 6'(m_addr), m_full, m_rd, m_sw,
                 m_act && !m_rel && m_t == SETUP + 1, m_act && !m_rel, m_frame, m_err};
      if (chk_on) begin
        checks++;
        if (dut_vec !== exp_vec) begin
          errors++;
          $display("FAIL cycle t=%0t outputs got=%h exp=%h", $time, dut_vec, exp_vec);
        end
      end
    end
  end
  task automatic cyc(input bit e, input bit v, input bit d);
    @(negedge clk);
    en = e; vld = v; done = d;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; en = 0; vld = 0; done = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL reset_state got=%h exp=0", dut_vec); end
    rst_n = 1;
    chk_on = 1;
  endtask
  task automatic test_fill();
    int n = 0;
    repeat (BB) cyc(1, 1, 0);
    checks += 3;
    if (o_bank_full !== 2'b01) begin errors++; $display("FAIL fill_full got=%b exp=01", o_bank_full); end
    if (o_wr_bank !== 1'b1) begin errors++; $display("FAIL fill_bank got=%b exp=1", o_wr_bank); end
    if (o_wr_addr !== 6'd0) begin errors++; $display("FAIL fill_addr got=%0d exp=0", o_wr_addr); end
    while (o_pe_start !== 1'b1 && n < 20) begin cyc(1, 0, 0); n++; end
    checks++;
    if (n != SETUP + 1) begin errors++; $display("FAIL start_latency got=%0d exp=%0d", n, SETUP + 1); end
  endtask
  task automatic test_both_full();
    repeat (BB) cyc(1, 1, 0);
    checks += 2;
    if (o_bank_full !== 2'b11) begin errors++; $display("FAIL both_full got=%b exp=11", o_bank_full); end
    if (o_din_rdy !== 1'b0) begin errors++; $display("FAIL both_rdy got=%b exp=0", o_din_rdy); end
    cyc(1, 1, 0);
    checks += 2;
    if (o_wr_addr !== 6'd0) begin errors++; $display("FAIL blocked_addr got=%0d exp=0", o_wr_addr); end
    if (o_bank_full !== 2'b11) begin errors++; $display("FAIL blocked_full got=%b exp=11", o_bank_full); end
  endtask
  task automatic test_release();
    cyc(1, 0, 1);
    checks++;
    if (o_switch_pingpong !== 1'b0) begin errors++; $display("FAIL early_switch got=%b exp=0", o_switch_pingpong); end
    cyc(1, 0, 0);
    checks += 5;
    if (o_switch_pingpong !== 1'b1) begin errors++; $display("FAIL switch got=%b exp=1", o_switch_pingpong); end
    if (o_rd_sel !== 1'b1) begin errors++; $display("FAIL rd_sel got=%b exp=1", o_rd_sel); end
    if (o_bank_full !== 2'b10) begin errors++; $display("FAIL rel_full got=%b exp=10", o_bank_full); end
    if (o_frame_cnt !== 16'd1) begin errors++; $display("FAIL frame got=%0d exp=1", o_frame_cnt); end
    if (o_din_rdy !== 1'b1) begin errors++; $display("FAIL rel_rdy got=%b exp=1", o_din_rdy); end
    cyc(1, 0, 0);
    checks++;
    if (o_switch_pingpong !== 1'b0) begin errors++; $display("FAIL switch_width got=%b exp=0", o_switch_pingpong); end
  endtask
  task automatic test_enable();
    do_reset();
    repeat (10) cyc(1, 1, 0);
    repeat (3) cyc(0, 1, 0);
    checks += 2;
    if (o_wr_addr !== 6'd10) begin errors++; $display("FAIL en_hold got=%0d exp=10", o_wr_addr); end
    if (o_din_rdy !== 1'b0) begin errors++; $display("FAIL en_rdy got=%b exp=0", o_din_rdy); end
    repeat (23) cyc(1, 1, 0);
    checks++;
    if (o_bank_full !== 2'b00) begin errors++; $display("FAIL en_early_full got=%b exp=00", o_bank_full); end
    cyc(1, 1, 0);
    checks++;
    if (o_bank_full !== 2'b01) begin errors++; $display("FAIL en_full got=%b exp=01", o_bank_full); end
  endtask
  task automatic test_async_reset();
    int n = 0;
    while (o_pe_start !== 1'b1 && n < 20) begin cyc(1, 0, 0); n++; end
    checks++;
    if (o_pe_busy !== 1'b1) begin errors++; $display("FAIL run_busy got=%b exp=1", o_pe_busy); end
    @(negedge clk);
    #2 en = 0; rst_n = 0;
    #1;
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL async_reset got=%h exp=0", dut_vec); end
    done = 1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== '0) begin errors++; $display("FAIL reset_hold got=%h exp=0", dut_vec); end
    end
    @(negedge clk);
    done = 0; rst_n = 1;
  endtask
  task automatic test_random();
    do_reset();
    repeat (3000) cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    checks++;
    if (o_frame_cnt !== m_frame) begin errors++; $display("FAIL rand_frames got=%0d exp=%0d", o_frame_cnt, m_frame); end
  endtask
`ifdef PINGPONG_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    do_reset();
    repeat (BB) cyc(1, 1, 0);
    while (o_pe_start !== 1'b1 && n < 20) begin cyc(1, 0, 0); n++; end
    n = 0;
    while (o_switch_pingpong !== 1'b1 && n < 100) begin cyc(1, 0, 0); n++; end
    checks += 3;
    if (n != TMO + 1) begin errors++; $display("FAIL tmo_latency got=%0d exp=%0d", n, TMO + 1); end
    if (o_err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag got=%b exp=1", o_err_timeout); end
    if (o_bank_full !== 2'b00) begin errors++; $display("FAIL tmo_full got=%b exp=00", o_bank_full); end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_fill();
    test_both_full();
    test_release();
    test_enable();
    test_async_reset();
    test_random();
`ifdef PINGPONG_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
